// File: rtl/mem_arbiter.sv
// Fetch / load-store arbiter onto one fixed-latency RAM; one access in flight, rvalid at T+2+MEM_LAT.
// Define MEM_ARB_RR_EN for round-robin on simultaneous requests (default: load/store fixed priority).
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                ls_req,
  input  logic                ls_we,
  input  logic [DATA_W/8-1:0] ls_be,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic [DATA_W-1:0]   ls_wdata,
  output logic                ls_gnt,
  output logic                ls_rvalid,
  output logic [DATA_W-1:0]   ls_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);
  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              own_ls_q, own_ls_d;
  logic              we_q, we_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              if_rvalid_q, if_rvalid_d, ls_rvalid_q, ls_rvalid_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d, ls_rdata_q, ls_rdata_d;
  logic              pick_ls;

`ifdef MEM_ARB_RR_EN
  // rr_q high means fetch wins the next tie
  logic rr_q, rr_d;
  assign pick_ls = ls_req & (~if_req | ~rr_q);
`else
  assign pick_ls = ls_req;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    own_ls_d    = own_ls_q;
    we_d        = we_q;
    be_d        = be_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    if_rvalid_d = 1'b0;
    ls_rvalid_d = 1'b0;
    if_rdata_d  = if_rdata_q;
    ls_rdata_d  = ls_rdata_q;
    if_gnt      = 1'b0;
    ls_gnt      = 1'b0;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
`ifdef MEM_ARB_RR_EN
    rr_d        = rr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (!rst && (if_req || ls_req)) begin
          if_gnt   = ~pick_ls;
          ls_gnt   = pick_ls;
          own_ls_d = pick_ls;
          we_d     = pick_ls & ls_we;
          be_d     = pick_ls ? ls_be : '1;
          addr_d   = pick_ls ? ls_addr : if_addr;
          wdata_d  = ls_wdata;
          state_d  = S_ISSUE;
`ifdef MEM_ARB_RR_EN
          rr_d     = pick_ls;
`endif
        end
      end
      S_ISSUE: begin
        mem_en  = 1'b1;
        mem_we  = we_q;
        cnt_d   = CNT_LAST;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
          // the RAM word is valid only in this last wait cycle
          if (own_ls_q) begin
            ls_rvalid_d = 1'b1;
            if (!we_q) ls_rdata_d = mem_rdata;
          end else begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = mem_rdata;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      own_ls_q    <= 1'b0;
      we_q        <= 1'b0;
      be_q        <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      if_rvalid_q <= 1'b0;
      ls_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      ls_rdata_q  <= '0;
`ifdef MEM_ARB_RR_EN
      rr_q        <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      own_ls_q    <= own_ls_d;
      we_q        <= we_d;
      be_q        <= be_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      if_rvalid_q <= if_rvalid_d;
      ls_rvalid_q <= ls_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      ls_rdata_q  <= ls_rdata_d;
`ifdef MEM_ARB_RR_EN
      rr_q        <= rr_d;
`endif
    end
  end

  assign mem_be    = be_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign if_rvalid = if_rvalid_q;
  assign ls_rvalid = ls_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign ls_rdata  = ls_rdata_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, 32, address width.
REQ-002 SHALL have parameter DATA_W, 32, data width (byte enables DATA_W/8 bits).
REQ-003 SHALL have parameter MEM_LAT, 1, RAM read latency in cycles from mem_en sample to mem_rdata valid (>=1).
REQ-004 SHALL have ports: clk  in  1  clock; rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have fetch ports: if_req in 1 request; if_addr in ADDR_W; if_gnt out 1 grant; if_rvalid out 1 response pulse; if_rdata out DATA_W.
REQ-006 SHALL have load/store ports: ls_req in 1; ls_we in 1 write; ls_be in DATA_W/8; ls_addr in ADDR_W; ls_wdata in DATA_W; ls_gnt out 1; ls_rvalid out 1; ls_rdata out DATA_W.
REQ-007 SHALL have RAM ports: mem_en out 1; mem_we out 1; mem_be out DATA_W/8; mem_addr out ADDR_W; mem_wdata out DATA_W; mem_rdata in DATA_W.

Function
REQ-008 SHALL implement states IDLE, ISSUE, WAIT; one access in flight at most.
REQ-009 In IDLE with any req high, SHALL assert exactly one gnt combinationally that cycle (T), latch winner's fields at the edge, go to ISSUE.
REQ-010 In IDLE with no req, SHALL keep both gnt low and stay in IDLE.
REQ-011 ISSUE (T+1) SHALL drive mem_en=1 and latched addr/we/be/wdata for exactly one cycle, then go to WAIT.
REQ-012 WAIT SHALL last exactly MEM_LAT cycles via down-counter; at end of last WAIT cycle SHALL capture mem_rdata (reads only) into winner's rdata register and go to IDLE.
REQ-013 Winner's rvalid SHALL be a registered one-cycle pulse in cycle T+2+MEM_LAT (T+3 at MEM_LAT=1), for reads and writes alike.
REQ-014 On writes, ls_rdata SHALL retain its previous value; if_rdata only changes on fetch responses.
REQ-015 Fetch accesses SHALL drive mem_we=0, mem_be all-ones.
REQ-016 mem_en SHALL be low outside ISSUE; mem_we SHALL never be high while mem_en is low.
REQ-017 A new grant MAY occur in the same cycle as a rvalid pulse; throughput one access per MEM_LAT+2 cycles.
REQ-018 req seen outside IDLE SHALL not be granted until next IDLE; requester holds req and fields until gnt; req dropped before gnt SHALL cause no access.
REQ-019 Single requester SHALL always win regardless of arbitration mode.

Reset
REQ-020 rst high SHALL immediately force state IDLE, counter 0, mem_en=0, mem_we=0, both gnt=0, both rvalid=0, both rdata=0, round-robin pointer to "fetch next".
REQ-021 rst mid-access SHALL abort it; no rvalid SHALL be produced for the aborted access.

Configuration
REQ-022 With MEM_ARB_RR_EN defined, simultaneous requests SHALL alternate: requester not granted last wins; pointer updates on every grant.
REQ-023 Without MEM_ARB_RR_EN, simultaneous requests SHALL always grant ls (fixed priority); no pointer register SHALL exist.

Verification
REQ-024 Fetch read: if_req, if_addr=0x8, RAM word 0x00500093 -> if_gnt at T, mem_en/addr 0x8 at T+1, if_rvalid with if_rdata=0x00500093 at T+3.
REQ-025 Store: ls_we=1, ls_be=0x3, ls_addr=0x10, ls_wdata=0xDEADBEEF -> mem_we=1, mem_be=0x3 at T+1; ls_rvalid at T+3; ls_rdata unchanged.
REQ-026 Both req held 4 grants, no macro -> ls,ls,ls,ls; with MEM_ARB_RR_EN -> if,ls,if,ls.
REQ-027 MEM_LAT=3, back-to-back fetch -> grants at T and T+5, rvalids at T+5 and T+10.
REQ-028 rst pulsed during WAIT -> mem_en=0 same cycle, no rvalid; next request served normally with REQ-024 timing.
